// File: rtl/audio_mix_pkg.sv
// audio_mix_pkg: shared default widths, datapath width helpers and FSM encoding for the voice mixer
package audio_mix_pkg;
  localparam int SAMPLE_W_DEF = 16;
  localparam int GAIN_W_DEF = 8;
  typedef enum logic [2:0] {IDLE, FETCH, MAC, SCALE, SAT} state_t;
  function automatic int prod_w(input int sw, input int gw);
    return sw + gw + 1;
  endfunction
  function automatic int acc_w(input int sw, input int gw, input int nv);
    return prod_w(sw, gw) + $clog2(nv);
  endfunction
  function automatic int mix_w(input int sw, input int gw, input int nv);
    return acc_w(sw, gw, nv) + gw + 1;
  endfunction
  function automatic int sel_w(input int nv);
    return nv > 1 ? $clog2(nv) : 1;
  endfunction
endpackage

// File: rtl/audio_saturate.sv
// audio_saturate: arithmetic shift right by 2 of the scaled mix, clamped to 32-bit signed with a clip flag
module audio_saturate #(
  parameter int W = 37
) (
  input logic signed [W-1:0] mix,
  output logic [31:0] q,
  output logic clip
);
  localparam logic signed [W-1:0] max_v = W'(64'sd2147483647);
  localparam logic signed [W-1:0] min_v = W'(-64'sd2147483648);
  logic signed [W-1:0] s;
  logic hi;
  logic lo;
  assign s = mix >>> 2;
  assign hi = s > max_v;
  assign lo = s < min_v;
  assign clip = hi | lo;
  assign q = hi ? 32'h7fff_ffff : lo ? 32'h8000_0000 : s[31:0];
endmodule

// File: rtl/voice_mixer.sv
// voice_mixer: once per LRCLK frame fetches every voice, applies gain, accumulates, scales by master volume and saturates
module voice_mixer import audio_mix_pkg::*; #(
  parameter int NUM_VOICES = 8,
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int GAIN_W = GAIN_W_DEF
) (
  input logic MCLK,
  input logic RESET,
  input logic LRCLK,
  output logic VOICE_REQ,
  output logic [sel_w(NUM_VOICES)-1:0] VOICE_SEL,
  input logic VOICE_VALID,
  input logic signed [SAMPLE_W-1:0] VOICE_SAMPLE,
  input logic [GAIN_W-1:0] VOICE_GAIN,
  input logic VOICE_ACTIVE,
  input logic [GAIN_W-1:0] MASTER_VOL,
  output logic [31:0] AUDIO,
  output logic SAMPLE_TICK,
  output logic CLIP,
  output logic LATE
);
  localparam int pw = prod_w(SAMPLE_W, GAIN_W);
  localparam int aw = acc_w(SAMPLE_W, GAIN_W, NUM_VOICES);
  localparam int mw = mix_w(SAMPLE_W, GAIN_W, NUM_VOICES);
  localparam int sw = sel_w(NUM_VOICES);
  state_t state;
  logic lr_q;
  logic frame_start;
  logic signed [pw-1:0] prod;
  logic signed [aw-1:0] acc;
  logic signed [mw-1:0] mix;
  logic [31:0] result_reg;
  logic result_valid;
  logic [31:0] sat_q;
  logic sat_clip;
  assign frame_start = lr_q & ~LRCLK;
  assign VOICE_REQ = state == FETCH;
  audio_saturate #(.W(mw)) u_sat (
    .mix(mix),
    .q(sat_q),
    .clip(sat_clip)
  );
  // Frame sequencer: a frame start always restarts the mix from voice 0, publishing the last completed result
  always_ff @(posedge MCLK or posedge RESET)
    if (RESET) begin
      state <= IDLE;
      lr_q <= 1'b0;
      VOICE_SEL <= '0;
      prod <= '0;
      acc <= '0;
      mix <= '0;
      result_reg <= '0;
      result_valid <= 1'b1;
      AUDIO <= '0;
      SAMPLE_TICK <= 1'b0;
      CLIP <= 1'b0;
      LATE <= 1'b0;
    end else begin
      lr_q <= LRCLK;
      SAMPLE_TICK <= frame_start;
      if (frame_start) begin
        if (result_valid) AUDIO <= result_reg;
        if (state != IDLE) LATE <= 1'b1;
        acc <= '0;
        VOICE_SEL <= '0;
        result_valid <= 1'b0;
        state <= FETCH;
      end else
        case (state)
          FETCH:
            if (VOICE_VALID) begin
              prod <= VOICE_ACTIVE ? pw'(VOICE_SAMPLE) * pw'({1'b0, VOICE_GAIN}) : '0;
              state <= MAC;
            end
          MAC: begin
            acc <= acc + aw'(prod);
            if (VOICE_SEL == sw'(NUM_VOICES - 1)) state <= SCALE;
            else begin
              VOICE_SEL <= VOICE_SEL + sw'(1);
              state <= FETCH;
            end
          end
          SCALE: begin
            mix <= mw'(acc) * mw'({1'b0, MASTER_VOL});
            state <= SAT;
          end
          SAT: begin
            result_reg <= sat_q;
            result_valid <= 1'b1;
            if (sat_clip) CLIP <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer: randomized responder and frame driver checked against an arithmetic mixing model
module tb_voice_mixer;
  logic mclk = 1'b0;
  logic reset = 1'b1;
  logic lrclk = 1'b1;
  logic voice_req;
  logic [2:0] voice_sel;
  logic voice_valid;
  logic signed [15:0] voice_sample;
  logic [7:0] voice_gain;
  logic voice_active;
  logic [7:0] vol = 8'd0;
  logic [31:0] audio;
  logic sample_tick;
  logic clip;
  logic late;
  logic signed [15:0] smp [8];
  logic [7:0] gain [8];
  logic act [8];
  int w_min = 0;
  int w_max = 5;
  int txn = 0;
  int sel_chg = 0;
  int errors = 0;
  int checks = 0;
  logic [31:0] aud_m = '0;
  bit clip_m = 0;
  bit late_m = 0;
  bit pend_done = 1;
  logic [31:0] pend_val = '0;
  bit pend_clip = 0;
  voice_mixer dut (
    .MCLK(mclk),
    .RESET(reset),
    .LRCLK(lrclk),
    .VOICE_REQ(voice_req),
    .VOICE_SEL(voice_sel),
    .VOICE_VALID(voice_valid),
    .VOICE_SAMPLE(voice_sample),
    .VOICE_GAIN(voice_gain),
    .VOICE_ACTIVE(voice_active),
    .MASTER_VOL(vol),
    .AUDIO(audio),
    .SAMPLE_TICK(sample_tick),
    .CLIP(clip),
    .LATE(late)
  );
  always #5 mclk = ~mclk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Mixed output as the sum of gained active samples, times volume, divided by 4 (floor) and clamped to 32-bit signed
  function automatic void ref_mix(output logic [31:0] v, output bit c);
    longint s = 0;
    for (int i = 0; i < 8; i++) if (act[i]) s += longint'(smp[i]) * longint'(gain[i]);
    s = s * longint'(vol);
    s = s >>> 2;
    c = s > 64'sd2147483647 || s < -64'sd2147483648;
    v = s > 64'sd2147483647 ? 32'h7fff_ffff : s < -64'sd2147483648 ? 32'h8000_0000 : 32'(s);
  endfunction
  task automatic set_all(input logic [15:0] s, input logic [7:0] g, input logic [7:0] mv);
    for (int i = 0; i < 8; i++) begin
      smp[i] = s;
      gain[i] = g;
      act[i] = 1'b1;
    end
    vol = mv;
  endtask
  task automatic rand_tables();
    for (int i = 0; i < 8; i++) begin
      smp[i] = 16'($urandom);
      gain[i] = 8'($urandom);
      act[i] = 1'($urandom);
    end
    vol = 8'($urandom);
  endtask
  // One LRCLK period starting with its falling edge; the mix started here is checked at the next falling edge
  task automatic frame(input int wmin, input int wmax, input bit rst_mid);
    logic [31:0] v;
    bit c;
    bit done;
    bit aborted;
    logic [2:0] sb;
    ref_mix(v, c);
    done = wmax <= 5;
    w_min = wmin;
    w_max = wmax;
    @(negedge mclk);
    sb = voice_sel;
    lrclk = 1'b0;
    aborted = !pend_done;
    if (pend_done) begin
      aud_m = pend_val;
      clip_m |= pend_clip;
    end else late_m = 1;
    pend_done = done;
    pend_val = v;
    pend_clip = c;
    txn = 0;
    sel_chg = 0;
    @(negedge mclk);
    chk("audio", audio, aud_m);
    chk("clip", clip, clip_m);
    chk("late", late, late_m);
    chk("tick_high", sample_tick, 1);
    if (aborted) begin
      chk("sel_was_busy", sb != 3'd0, 1);
      chk("sel_restart", voice_sel, 0);
      chk("req_restart", voice_req, 1);
    end
    @(negedge mclk);
    chk("tick_low", sample_tick, 0);
    if (rst_mid) begin
      chk("req_mid", voice_req, 1);
      reset = 1'b1;
      #1;
      chk("rst_audio", audio, 0);
      chk("rst_clip", clip, 0);
      chk("rst_late", late, 0);
      chk("rst_req", voice_req, 0);
      chk("rst_sel", voice_sel, 0);
      chk("rst_tick", sample_tick, 0);
      repeat (3) @(negedge mclk);
      reset = 1'b0;
      aud_m = '0;
      clip_m = 0;
      late_m = 0;
      pend_done = 1;
      pend_val = '0;
      pend_clip = 0;
      done = 0;
    end
    repeat (100) @(negedge mclk);
    lrclk = 1'b1;
    repeat (128) @(negedge mclk);
    if (done && !aborted) begin
      chk("txn_count", txn, 8);
      chk("sel_stable", sel_chg, 0);
    end
  endtask
  // Responder: random wait states while requested, random noise on VALID while not requested
  initial begin
    int wc = 0;
    bit pr = 0;
    logic [2:0] ps = '0;
    voice_valid = 1'b0;
    voice_sample = '0;
    voice_gain = '0;
    voice_active = 1'b0;
    forever begin
      @(negedge mclk);
      voice_valid = 1'b0;
      if (voice_req && pr && voice_sel != ps) sel_chg++;
      if (voice_req) begin
        if (!pr) wc = int'($urandom_range(w_max, w_min));
        if (wc == 0) begin
          voice_valid = 1'b1;
          voice_sample = smp[voice_sel];
          voice_gain = gain[voice_sel];
          voice_active = act[voice_sel];
          txn++;
        end else wc--;
      end else begin
        voice_valid = 1'($urandom);
        voice_sample = 16'($urandom);
        voice_gain = 8'($urandom);
        voice_active = 1'($urandom);
      end
      pr = voice_req;
      ps = voice_sel;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    rand_tables();
    repeat (3) @(negedge mclk);
    chk("init_audio", audio, 0);
    chk("init_clip", clip, 0);
    chk("init_late", late, 0);
    chk("init_req", voice_req, 0);
    chk("init_sel", voice_sel, 0);
    chk("init_tick", sample_tick, 0);
    reset = 1'b0;
    repeat (5) @(negedge mclk);
    for (int i = 0; i < 8; i++) act[i] = 1'b0;
    smp[0] = 16'h4000;
    gain[0] = 8'd128;
    act[0] = 1'b1;
    vol = 8'd128;
    frame(0, 5, 0);
    set_all(16'h7fff, 8'd255, 8'd255);
    frame(0, 5, 0);
    set_all(16'h8000, 8'd255, 8'd255);
    frame(0, 5, 0);
    for (int k = 0; k < 12; k++) begin
      rand_tables();
      frame(0, 5, 0);
    end
    for (int k = 0; k < 2; k++) begin
      rand_tables();
      frame(40, 40, 0);
    end
    for (int k = 0; k < 2; k++) begin
      rand_tables();
      frame(0, 5, 0);
    end
    rand_tables();
    frame(40, 40, 1);
    for (int k = 0; k < 3; k++) begin
      rand_tables();
      frame(0, 5, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/voice_mixer.md
# voice_mixer

Time-multiplexed voice mixer in the MCLK domain, directly upstream of the I2S transmitter. Once per audio frame it fetches one sample per voice over a request/valid handshake, scales each by its gain, accumulates, applies master volume and saturates. The result is a 32-bit word presented on AUDIO for the transmitter to serialize. It pulses SAMPLE_TICK so the voice generators advance one sample per frame.

## Interface
- NUM_VOICES, 8: voices mixed per frame; range 1..64.
- SAMPLE_W, 16: signed voice sample width.
- GAIN_W, 8: unsigned per-voice gain and master volume width.
- MCLK  in  1  256×44.1 kHz master clock.
- RESET  in  1  asynchronous, active-high reset.
- LRCLK  in  1  frame clock from the I2S transmitter, synchronous to MCLK.
- VOICE_REQ  out  1  fetch request for voice VOICE_SEL.
- VOICE_SEL  out  $clog2(NUM_VOICES)  voice index being fetched.
- VOICE_VALID  in  1  responder strobe; qualifies the three VOICE_* data inputs.
- VOICE_SAMPLE  in  SAMPLE_W  signed sample.
- VOICE_GAIN  in  GAIN_W  unsigned gain.
- VOICE_ACTIVE  in  1  0 forces this voice's product to 0.
- MASTER_VOL  in  GAIN_W  unsigned master volume; sampled in SCALE.
- AUDIO  out  32  signed mixed sample to the I2S transmitter.
- SAMPLE_TICK  out  1  one-MCLK pulse at each frame start.
- CLIP  out  1  sticky; set when saturation occurs.
- LATE  out  1  sticky; set when a frame boundary arrives before the mix completes.

## Operation
- Frame start is an LRCLK falling edge, detected with a registered copy lr_q: lr_q & ~LRCLK.
- On frame start:
  - AUDIO <= result_reg, but only if result_valid.
  - SAMPLE_TICK pulses.
  - acc <= 0 and sel <= 0, then the FSM enters FETCH.
  - result_valid clears.
- FSM states: IDLE, FETCH, MAC, SCALE, SAT.
  - IDLE: waits for frame start.
  - FETCH: VOICE_REQ=1, VOICE_SEL=sel. On VOICE_VALID, prod <= ACTIVE ? SAMPLE × {0,GAIN} : 0, then go to MAC.
  - MAC: VOICE_REQ=0; acc <= acc + prod. If sel==NUM_VOICES-1 go to SCALE, else sel++ and go to FETCH.
  - SCALE: mix <= acc × {0,MASTER_VOL}.
  - SAT: result_reg <= sat32(mix >>> 2). Set result_valid, and set CLIP if saturated. Go to IDLE.
- Widths:
  - prod is SAMPLE_W+GAIN_W+1 bits.
  - acc is prod width + $clog2(NUM_VOICES) bits (28 at defaults).
  - mix is acc width + GAIN_W+1 bits.
  - Shifts are arithmetic. Saturation clamps to 0x7FFFFFFF / 0x80000000.
- Frame start while not IDLE:
  - Set LATE. AUDIO holds its previous value.
  - Abort the current mix and restart from voice 0 in the same cycle.
- Handshake: VOICE_SEL is stable while VOICE_REQ=1. The responder may assert VOICE_VALID in any cycle in which VOICE_REQ=1. VOICE_VALID while VOICE_REQ=0 is ignored.
- RESET: asynchronous to state IDLE. Reset values:
  - AUDIO, CLIP, LATE, VOICE_REQ, VOICE_SEL, SAMPLE_TICK = 0.
  - acc = 0, result_reg = 0, result_valid = 1, lr_q = 0.
  - A reset mid-mix discards all partial state.

## Timing
- Frame start is detected in cycle t. AUDIO changes at the t+1 edge, which is ≥3 MCLK before the transmitter's next SCLK rising edge.
- VOICE_REQ is asserted from t+1.
- Minimum mix latency is 2·NUM_VOICES+2 cycles (18 at defaults) with zero-wait responders, leaving a budget of 256 MCLK per frame.
- Pipeline latency: the sample mixed in frame N appears on AUDIO at the start of frame N+1.
- CLIP and LATE clear only on RESET.

## Structure
- Package audio_mix_pkg holds:
  - the SAMPLE_W and GAIN_W defaults;
  - the prod, acc and mix width functions;
  - the FSM state enum (IDLE, FETCH, MAC, SCALE, SAT).
- One sub-module: audio_saturate, combinational arithmetic shift-right by 2 with clamp to 32-bit signed and a clip flag.

## Test plan
- Single voice: voice0 SAMPLE=0x4000, GAIN=128, ACTIVE=1; others ACTIVE=0; MASTER_VOL=128. Next frame start -> AUDIO=0x04000000, CLIP=0.
- Positive saturation: all 8 voices SAMPLE=0x7FFF, GAIN=255; MASTER_VOL=255 -> AUDIO=0x7FFFFFFF, CLIP=1.
- Negative saturation: all 8 voices SAMPLE=0x8000, GAIN=255; MASTER_VOL=255 -> AUDIO=0x80000000, CLIP=1.
- Responder stalls 40 cycles per voice (over budget) -> LATE=1, AUDIO holds its previous value, and VOICE_SEL restarts at 0 on the next frame start.
- Random VOICE_VALID wait states of 0-5 cycles -> AUDIO matches the reference model every frame; VOICE_SEL never changes while VOICE_REQ=1; exactly 8 REQ/VALID transactions per frame.
- RESET asserted mid-FETCH -> all outputs 0 immediately; the first frame after release outputs AUDIO=0 with LATE=0.
